// File: rtl/key_conditioner.sv
// Push-button debouncer with press strobe, level and optional auto-repeat.
// Define KEY_AUTOREPEAT_EN to build the repeat timer and key_long.
module key_conditioner #(
    parameter int DB_CYCLES         = 1000000,
    parameter int RPT_DELAY_CYCLES  = 25000000,
    parameter int RPT_PERIOD_CYCLES = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic key_pulse,
    output logic key_level,
    output logic key_long
);

    localparam int MAX_A = (DB_CYCLES > RPT_DELAY_CYCLES) ?
                           DB_CYCLES : RPT_DELAY_CYCLES;
    localparam int MAXP  = (MAX_A > RPT_PERIOD_CYCLES) ?
                           MAX_A : RPT_PERIOD_CYCLES;
    localparam int CW    = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } state_t;

    state_t        state;
    logic [CW-1:0] db_cnt;
    logic          sync_a;
    logic          sync_b;
    logic          pressed;
    logic          pulse_q;
    logic          level_q;
    logic          entering_held;
    logic          rpt_pulse;
    logic          rpt_long;

    assign pressed       = ~sync_b;
    assign entering_held = (state == DB_PRESS) && pressed &&
                           (db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= btn_n;
            sync_b <= sync_a;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CW-1:0] DLY_LAST = CW'(RPT_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(RPT_PERIOD_CYCLES - 1);

    logic [CW-1:0] rpt_cnt;
    logic          rpt_due;

    assign rpt_due   = rpt_long ? (rpt_cnt == PER_LAST)
                                : (rpt_cnt == DLY_LAST);
    assign rpt_pulse = (state == HELD) && rpt_due;

    // Keeps running through release bounce so the cadence is not disturbed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rpt_cnt  <= '0;
            rpt_long <= 1'b0;
        end else if (entering_held) begin
            rpt_cnt  <= '0;
            rpt_long <= 1'b0;
        end else if (state == HELD || state == DB_RELEASE) begin
            if (rpt_due) begin
                rpt_cnt  <= '0;
                rpt_long <= 1'b1;
            end else begin
                rpt_cnt  <= rpt_cnt + 1'b1;
            end
        end else begin
            rpt_cnt  <= '0;
            rpt_long <= 1'b0;
        end
    end
`else
    assign rpt_pulse = 1'b0;
    assign rpt_long  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            db_cnt  <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            pulse_q <= rpt_pulse;
            unique case (state)
                IDLE: begin
                    if (pressed) begin
                        state  <= DB_PRESS;
                        db_cnt <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!pressed) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state   <= HELD;
                        pulse_q <= 1'b1;
                        level_q <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state  <= DB_RELEASE;
                        db_cnt <= '0;
                    end
                end
                DB_RELEASE: begin
                    if (pressed) begin
                        state <= HELD;
                    end else if (db_cnt == DB_LAST) begin
                        state   <= IDLE;
                        db_cnt  <= '0;
                        level_q <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // One output stage aligns the strobe with the required press latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_pulse <= 1'b0;
            key_level <= 1'b0;
            key_long  <= 1'b0;
        end else begin
            key_pulse <= pulse_q;
            key_level <= level_q;
            key_long  <= rpt_long & level_q;
        end
    end

endmodule
